layer_out_serializer: RTL and testbench
=======================================

Name: layer_out_serializer

Overview:
- Sits directly downstream of one layer of neuron instances.
- Collects each neuron's registered output word on its individual outvalid pulse.
- Once every neuron in the layer has reported, replays the words as a contiguous one-word-per-cycle stream, neuron 0 first.
- The stream drives the next layer's shared myinput/myinputValid bus; there is no backpressure.

Parameters:
- NUM_NEURONS, 30: neurons in the producing layer, and the number of words per burst. Must be ≥1.
- DATA_WIDTH, 16: width of each neuron output word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_NEURONS*DATA_WIDTH  packed neuron outputs; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_NEURONS  per-neuron outvalid pulses.
- data_out  output  DATA_WIDTH  serialized word, feeds next layer myinput.
- data_out_valid  output  1  word valid, feeds next layer myinputValid.
- data_out_last  output  1  high with the final word of a burst.
- overrun  output  1  sticky error flag.
- data_out_idx  output  $clog2(NUM_NEURONS) (min 1)  neuron index of the current word. Present only with LAYER_SER_INDEX_EN.

Behaviour:
- Reset: in the cycle after rst=1, state=COLLECT, captured mask=0, idx=0, and all outputs are 0. rst overrides everything, including mid-burst; a burst in flight is truncated with no last pulse.
- Storage: one DATA_WIDTH register per neuron plus a NUM_NEURONS-bit captured mask.
- COLLECT state:
  - Each cycle, for every k with in_valid[k]=1, register word k and set mask[k].
  - If mask[k] was already set, the word is overwritten and overrun is set.
  - When (mask | in_valid) is all ones, the next state is SHIFT with idx=0 and mask cleared. This covers the case where all neurons fire in the same cycle.
- SHIFT state:
  - data_out = word[idx], data_out_valid=1. All outputs are registered.
  - The first word appears in the cycle after the completing capture edge, so latency is 1 cycle from the last in_valid to the first valid word.
  - idx increments each cycle. At idx=NUM_NEURONS-1, data_out_last=1 and the next state is COLLECT.
  - A burst is exactly NUM_NEURONS consecutive valid cycles with no gaps.
  - in_valid during SHIFT, except on the final word cycle, is dropped and sets overrun.
  - in_valid on the final word cycle is accepted into the fresh mask and data. This allows back-to-back layers.
  - If NUM_NEURONS=1, SHIFT lasts one cycle with valid and last both high.
- overrun: clears only on rst. It does not alter the sequencing.
- Outside SHIFT: data_out holds 0, and data_out_valid/data_out_last are 0.
- Arithmetic: pure data movement, no sign handling. idx compare is against NUM_NEURONS-1; idx never wraps past it.

Optional Feature:
- Macro: LAYER_SER_INDEX_EN.
- Defined: adds data_out_idx, registered alongside data_out and equal to the neuron number of the current word. It is 0 whenever data_out_valid=0. This is used by a downstream max-finder.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package:
  - State encoding constants: COLLECT=1'b0, SHIFT=1'b1.
  - An idx-width helper: max(1, clog2(N)).
  - No typedefs beyond that.
- One natural sub-module: layer_ser_capture, the per-neuron word register with mask bit and duplicate detection, instantiated NUM_NEURONS times in a generate loop. The FSM and output mux stay in the top.

Test Plan (N=4, W=16):
1. All in_valid=4'b1111 in one cycle with words 0x0001/0x0002/0x0003/0x0004 -> the next 4 cycles give data_out 1,2,3,4, valid=1, last only on 4, overrun=0.
2. Staggered pulses: neuron 2 at t0, neuron 0 at t3, neuron 3 at t5, neuron 1 at t9 -> the burst starts at t10, in order 0..3 with the correct words.
3. Duplicate: neuron 1 twice in COLLECT (0x00AA then 0x00BB) -> overrun=1 and the burst carries 0x00BB for index 1.
4. in_valid[0] during the second SHIFT word -> dropped, overrun=1, and the burst is unchanged. A pulse on neuron 0 on the last word cycle is instead retained, and the next burst needs only neurons 1–3.
5. rst asserted on the third SHIFT cycle -> the next cycle has valid=0, last=0, and a fresh 4-neuron collection is required.
6. With LAYER_SER_INDEX_EN defined, scenario 1 -> data_out_idx reads 0,1,2,3 then 0.

Source files
------------

// File: rtl/layer_out_serializer_pkg.sv
// Shared state encoding and index-width helper for the layer output serializer.
package layer_out_serializer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    SHIFT   = 1'b1
  } state_e;

  // Index width is max(1, clog2(n)) so a single-neuron layer still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_ser_capture.sv
// One neuron slot: word register plus captured-mask bit with duplicate detection.
// word_nxt_o exposes the value the register takes at the next edge so the top can forward it.
module layer_ser_capture #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept_i,
  input  logic                  clear_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] word_nxt_o,
  output logic                  mask_o,
  output logic                  dup_o
);

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  mask_q, mask_d;
  logic                  take;

  always_comb begin
    take   = accept_i & vld_i;
    word_d = take ? dat_i : word_q;
    mask_d = mask_q;
    // The completing capture still stores its word, but the mask restarts empty.
    if (clear_i) begin
      mask_d = 1'b0;
    end else if (take) begin
      mask_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      mask_q <= 1'b0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
    end
  end

  assign word_nxt_o = word_d;
  assign mask_o     = mask_q;
  assign dup_o      = take & mask_q;

endmodule

// File: rtl/layer_out_serializer.sv
// Collects one word per neuron, then replays them neuron 0 first, one per cycle, no backpressure.
// Optional LAYER_SER_INDEX_EN adds a registered data_out_idx port.
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int  NUM_NEURONS = 30,
  parameter int  DATA_WIDTH  = 16,
  localparam int IDX_W       = idx_width(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              data_out_valid,
  output logic                              data_out_last,
  output logic                              overrun
`ifdef LAYER_SER_INDEX_EN
  ,
  output logic [IDX_W-1:0]                  data_out_idx
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    overrun_q, overrun_d;

  logic [NUM_NEURONS-1:0]  mask;
  logic [NUM_NEURONS-1:0]  dup;
  logic [DATA_WIDTH-1:0]   word_nxt [NUM_NEURONS];
  logic                    is_collect, is_shift, final_word, complete, accept;

  assign is_collect = (state_q == COLLECT);
  assign is_shift   = (state_q == SHIFT);
  assign final_word = is_shift && (idx_q == LAST_IDX);
  assign complete   = is_collect && (&(mask | in_valid));
  // The final word cycle reopens capture so the next layer pass can start immediately.
  assign accept     = is_collect | final_word;

  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_slot
    layer_ser_capture #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .accept_i  (accept),
      .clear_i   (complete),
      .vld_i     (in_valid[k]),
      .dat_i     (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .word_nxt_o(word_nxt[k]),
      .mask_o    (mask[k]),
      .dup_o     (dup[k])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (complete) begin
      state_d = SHIFT;
      idx_d   = '0;
    end else if (is_shift) begin
      if (final_word) begin
        state_d = COLLECT;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Outputs are computed from next state so the first word lands one cycle after completion.
  always_comb begin
    overrun_d = overrun_q
              | (is_collect & (|dup))
              | (is_shift & ~final_word & (|in_valid));
    valid_d   = (state_d == SHIFT);
    last_d    = valid_d && (idx_d == LAST_IDX);
    data_d    = valid_d ? word_nxt[idx_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign data_out_last  = last_q;
  assign overrun        = overrun_q;

`ifdef LAYER_SER_INDEX_EN
  logic [IDX_W-1:0] idx_out_q, idx_out_d;

  assign idx_out_d = valid_d ? idx_d : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_out_q <= '0;
    end else begin
      idx_out_q <= idx_out_d;
    end
  end

  assign data_out_idx = idx_out_q;
`else
  // Index output not built; downstream sees only the word stream.
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with N=4, W=16.
module tb_layer_out_serializer;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_last;
  logic        overrun;
`ifdef LAYER_SER_INDEX_EN
  logic [1:0]  data_out_idx;
`endif

  int total = 0;
  int bad   = 0;

  layer_out_serializer #(
    .NUM_NEURONS(4),
    .DATA_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_last (data_out_last),
    .overrun       (overrun)
`ifdef LAYER_SER_INDEX_EN
    ,
    .data_out_idx  (data_out_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 4'b0000;
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3);
    in_valid = v;
    in_data  = {w3, w2, w1, w0};
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 4'b0000;
    in_data  = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_vld"},  data_out_valid, 1'b0);
    check({tag, "_last"}, data_out_last,  1'b0);
    check({tag, "_dat"},  data_out,       16'h0000);
`ifdef LAYER_SER_INDEX_EN
    check({tag, "_idx"},  data_out_idx,   2'd0);
`endif
  endtask

  // Checks the current cycle as word 0, then steps through words 1..3.
  task automatic burst(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check($sformatf("%s_vld%0d", tag, i),  data_out_valid, 1'b1);
      check($sformatf("%s_dat%0d", tag, i),  data_out,       w[i]);
      check($sformatf("%s_last%0d", tag, i), data_out_last,  (i == 3));
`ifdef LAYER_SER_INDEX_EN
      check($sformatf("%s_idx%0d", tag, i),  data_out_idx,   i[1:0]);
`endif
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 4'b0000;
    in_data  = '0;

    // 1: reset state, then all four neurons fire together
    do_reset();
    check_quiet("rst");
    check("rst_ovr", overrun, 1'b0);
    drive(4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    step();
    idle();
    burst("all", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    step();
    check_quiet("all_end");
    check("all_ovr", overrun, 1'b0);

    // 2: staggered pulses, burst starts the cycle after the t9 pulse
    do_reset();
    for (int t = 0; t < 10; t++) begin
      idle();
      case (t)
        0: drive(4'b0100, 16'h0000, 16'h0000, 16'h0030, 16'h0000);
        3: drive(4'b0001, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        5: drive(4'b1000, 16'h0000, 16'h0000, 16'h0000, 16'h0040);
        9: drive(4'b0010, 16'h0000, 16'h0020, 16'h0000, 16'h0000);
        default: ;
      endcase
      step();
      if (t < 9) check($sformatf("stag_wait%0d", t), data_out_valid, 1'b0);
    end
    idle();
    burst("stag", 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    check("stag_ovr", overrun, 1'b0);

    // 3: duplicate capture in COLLECT overwrites and flags overrun
    do_reset();
    drive(4'b0010, 16'h0000, 16'h00AA, 16'h0000, 16'h0000);
    step();
    check("dup_ovr0", overrun, 1'b0);
    drive(4'b0010, 16'h0000, 16'h00BB, 16'h0000, 16'h0000);
    step();
    check("dup_ovr1", overrun, 1'b1);
    check("dup_wait", data_out_valid, 1'b0);
    drive(4'b1101, 16'h0011, 16'h0000, 16'h0033, 16'h0044);
    step();
    idle();
    burst("dup", 16'h0011, 16'h00BB, 16'h0033, 16'h0044);

    // 4: pulse mid-burst is dropped; pulse on the final word is retained
    do_reset();
    drive(4'b1111, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
    step();
    idle();
    check("mid_d0", data_out, 16'h0005);
    step();
    check("mid_d1", data_out, 16'h0006);
    drive(4'b0001, 16'hDEAD, 16'h0000, 16'h0000, 16'h0000);
    step();
    idle();
    check("mid_d2",  data_out, 16'h0007);
    check("mid_ovr", overrun,  1'b1);
    step();
    check("mid_d3",   data_out,      16'h0008);
    check("mid_last", data_out_last, 1'b1);
    drive(4'b0001, 16'h0050, 16'h0000, 16'h0000, 16'h0000);
    step();
    idle();
    check_quiet("mid_end");
    check("mid_ovr_hold", overrun, 1'b1);
    drive(4'b1110, 16'h0000, 16'h0051, 16'h0052, 16'h0053);
    step();
    idle();
    burst("keep", 16'h0050, 16'h0051, 16'h0052, 16'h0053);

    // 5: reset on the third SHIFT cycle truncates the burst
    do_reset();
    drive(4'b1111, 16'h0009, 16'h000A, 16'h000B, 16'h000C);
    step();
    idle();
    check("trunc_d0", data_out, 16'h0009);
    step();
    check("trunc_d1", data_out, 16'h000A);
    step();
    check("trunc_d2", data_out, 16'h000B);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_quiet("trunc_rst");
    drive(4'b0111, 16'h0061, 16'h0062, 16'h0063, 16'h0000);
    step();
    idle();
    check("trunc_wait0", data_out_valid, 1'b0);
    step();
    check("trunc_wait1", data_out_valid, 1'b0);
    drive(4'b1000, 16'h0000, 16'h0000, 16'h0000, 16'h0064);
    step();
    idle();
    burst("fresh", 16'h0061, 16'h0062, 16'h0063, 16'h0064);
    step();
    check_quiet("fresh_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
